// File: rtl/adc_snap_capture.sv
// Snapshot capture of 8 x SAMPLE_W ADC sample words into on-chip RAM, read back through a valid/ready port.
// Optional macro ADC_SNAP_TWOS_COMP_EN: store two's-complement samples instead of raw offset binary.
module adc_snap_capture #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned SAMPLE_W   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SAMPLE_W-1:0]   adc_d0,
  input  logic [SAMPLE_W-1:0]   adc_d1,
  input  logic [SAMPLE_W-1:0]   adc_d2,
  input  logic [SAMPLE_W-1:0]   adc_d3,
  input  logic [SAMPLE_W-1:0]   adc_d4,
  input  logic [SAMPLE_W-1:0]   adc_d5,
  input  logic [SAMPLE_W-1:0]   adc_d6,
  input  logic [SAMPLE_W-1:0]   adc_d7,
  input  logic                  adc_dv,
  input  logic                  arm,
  input  logic                  trig_mode,
  input  logic [SAMPLE_W-2:0]   trig_level,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [8*SAMPLE_W-1:0] rd_data,
  output logic                  rd_last
);

  localparam int unsigned WORD_W = 8 * SAMPLE_W;
  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W  = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_END  = PTR_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_READ} state_e;

  state_e state_q, state_d;

  logic [SAMPLE_W-1:0] lane [8];
  logic [WORD_W-1:0]   wr_word;
  logic                trig_hit, wr_en, last_wr;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic [WORD_W-1:0]   mem [DEPTH];
  logic [WORD_W-1:0]   ram_q;

  logic                out_v_q, out_v_d, out_last_q, out_last_d;
  logic [WORD_W-1:0]   out_data_q, out_data_d;
  logic                skid_v_q, skid_v_d, skid_last_q, skid_last_d;
  logic [WORD_W-1:0]   skid_data_q, skid_data_d;
  logic                pend_q, pend_d, pend_last_q, pend_last_d;
  logic                pop, fetch;
  logic [1:0]          occ, occ_after;

  function automatic logic [SAMPLE_W-1:0] to_tc(input logic [SAMPLE_W-1:0] raw);
    return {~raw[SAMPLE_W-1], raw[SAMPLE_W-2:0]};
  endfunction

  // |tc| with -2**(SAMPLE_W-1) saturated to the largest positive magnitude
  function automatic logic [SAMPLE_W-2:0] mag(input logic [SAMPLE_W-1:0] tc);
    logic [SAMPLE_W-1:0] neg;
    neg = (~tc) + SAMPLE_W'(1);
    if (!tc[SAMPLE_W-1]) return tc[SAMPLE_W-2:0];
    if (neg[SAMPLE_W-1]) return '1;
    return neg[SAMPLE_W-2:0];
  endfunction

  always_comb begin
    lane[0] = adc_d0;
    lane[1] = adc_d1;
    lane[2] = adc_d2;
    lane[3] = adc_d3;
    lane[4] = adc_d4;
    lane[5] = adc_d5;
    lane[6] = adc_d6;
    lane[7] = adc_d7;
  end

  always_comb begin
    trig_hit = !trig_mode;
    for (int unsigned i = 1; i < 8; i += 2) begin
      if (mag(to_tc(lane[i])) >= trig_level) trig_hit = 1'b1;
    end
  end

  always_comb begin
    wr_word = '0;
    for (int unsigned i = 0; i < 8; i++) begin
`ifdef ADC_SNAP_TWOS_COMP_EN
      wr_word[i*SAMPLE_W +: SAMPLE_W] = to_tc(lane[i]);
`else
      wr_word[i*SAMPLE_W +: SAMPLE_W] = lane[i];
`endif
    end
  end

  assign wr_en   = adc_dv && (((state_q == S_ARMED) && trig_hit) || (state_q == S_CAPTURE));
  assign last_wr = (wr_ptr_q == PTR_LAST);
  assign pop     = out_v_q && rd_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (arm) state_d = S_ARMED;
      S_ARMED:   if (wr_en) state_d = last_wr ? S_READ : S_CAPTURE;
      S_CAPTURE: if (wr_en && last_wr) state_d = S_READ;
      S_READ: begin
        if (arm)                         state_d = S_ARMED;
        else if (pop && out_last_q)      state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_ARMED) || (state_q == S_CAPTURE);
    done = (state_q == S_READ);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (wr_en)                                            wr_ptr_d = wr_ptr_q + PTR_W'(1);
    else if ((state_q == S_IDLE) || (state_q == S_READ))  wr_ptr_d = '0;
  end

  // Output register + skid slot + one RAM read in flight: never more than two words owned.
  always_comb begin
    occ       = 2'(out_v_q) + 2'(skid_v_q) + 2'(pend_q);
    occ_after = occ - 2'(pop);
    fetch     = (state_q == S_READ) && (state_d == S_READ) && (rd_ptr_q != PTR_END)
                && (occ_after < 2'd2);
  end

  always_comb begin
    out_v_d     = out_v_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    skid_v_d    = skid_v_q;
    skid_last_d = skid_last_q;
    skid_data_d = skid_data_q;
    pend_d      = fetch;
    pend_last_d = (rd_ptr_q == PTR_LAST);
    rd_ptr_d    = fetch ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    if (state_d != S_READ) begin
      out_v_d     = 1'b0;
      out_last_d  = 1'b0;
      skid_v_d    = 1'b0;
      skid_last_d = 1'b0;
      pend_d      = 1'b0;
      pend_last_d = 1'b0;
      rd_ptr_d    = '0;
    end else if (!out_v_q || pop) begin
      if (skid_v_q) begin
        out_v_d     = 1'b1;
        out_last_d  = skid_last_q;
        out_data_d  = skid_data_q;
        skid_v_d    = pend_q;
        skid_last_d = pend_last_q;
        skid_data_d = ram_q;
      end else begin
        out_v_d     = pend_q;
        out_last_d  = pend_q && pend_last_q;
        if (pend_q) out_data_d = ram_q;
      end
    end else if (pend_q) begin
      skid_v_d    = 1'b1;
      skid_last_d = pend_last_q;
      skid_data_d = ram_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_v_q     <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      skid_v_q    <= 1'b0;
      skid_last_q <= 1'b0;
      skid_data_q <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_v_q     <= out_v_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      skid_v_q    <= skid_v_d;
      skid_last_q <= skid_last_d;
      skid_data_q <= skid_data_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_word;
    if (fetch) ram_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
  end

  assign rd_valid = out_v_q;
  assign rd_data  = out_data_q;
  assign rd_last  = out_last_q;

endmodule

// File: tb/tb_adc_snap_capture.sv
// Directed self-checking bench for adc_snap_capture (DEPTH_LOG2=8, SAMPLE_W=12).
module tb_adc_snap_capture;

  logic        clk = 1'b0;
  logic        rst, adc_dv, arm, trig_mode, rd_ready;
  logic [11:0] adc_d0, adc_d1, adc_d2, adc_d3, adc_d4, adc_d5, adc_d6, adc_d7;
  logic [10:0] trig_level;
  logic        busy, done, rd_valid, rd_last;
  logic [95:0] rd_data;

  int total = 0;
  int bad   = 0;
  logic [95:0] sent[$];
  logic [95:0] got_q[$];
  bit          got_last[$];
  int          unstable, first_cyc, last_cyc;
  bit          tmo;

  adc_snap_capture #(.DEPTH_LOG2(8), .SAMPLE_W(12)) dut (
    .clk(clk), .rst(rst),
    .adc_d0(adc_d0), .adc_d1(adc_d1), .adc_d2(adc_d2), .adc_d3(adc_d3),
    .adc_d4(adc_d4), .adc_d5(adc_d5), .adc_d6(adc_d6), .adc_d7(adc_d7),
    .adc_dv(adc_dv), .arm(arm), .trig_mode(trig_mode), .trig_level(trig_level),
    .busy(busy), .done(done), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [95:0] w, input logic dv);
    {adc_d7, adc_d6, adc_d5, adc_d4, adc_d3, adc_d2, adc_d1, adc_d0} = w;
    adc_dv = dv;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  function automatic logic [95:0] splat(input logic [11:0] v);
    return {8{v}};
  endfunction

  function automatic logic [95:0] mkw(input logic [11:0] q, input logic [11:0] i);
    return {i, q, i, q, i, q, i, q};
  endfunction

  function automatic logic [95:0] exp_of(input logic [95:0] w);
`ifdef ADC_SNAP_TWOS_COMP_EN
    return w ^ {8{12'h800}};
`else
    return w;
`endif
  endfunction

  // Collects n handshaken words; records hold-stability violations and timing.
  task automatic read_words(input int n, input int pct);
    logic [95:0] held_d;
    logic        held_l;
    bit          held_v;
    got_q.delete();
    got_last.delete();
    unstable  = 0;
    tmo       = 0;
    first_cyc = -1;
    last_cyc  = -1;
    held_v    = 0;
    held_d    = '0;
    held_l    = 1'b0;
    for (int cyc = 0; got_q.size() < n; cyc++) begin
      if (cyc > 20 * n + 50) begin
        tmo = 1;
        break;
      end
      rd_ready = ($urandom_range(99) < pct);
      if (held_v && rd_valid && (rd_data !== held_d || rd_last !== held_l)) unstable++;
      if (rd_valid && first_cyc < 0) first_cyc = cyc;
      if (rd_valid && rd_ready) begin
        got_q.push_back(rd_data);
        got_last.push_back(rd_last);
        last_cyc = cyc;
        held_v   = 0;
      end else if (rd_valid) begin
        held_v = 1;
        held_d = rd_data;
        held_l = rd_last;
      end
      tick();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; arm = 1'b0; rd_ready = 1'b0; trig_mode = 1'b0; trig_level = '0;
    set_word('0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", rd_valid); end
    total++; if (rd_last !== 1'b0)  begin bad++; $display("FAIL rst_last got=%b want=0", rd_last); end
    total++; if (rd_data !== '0)    begin bad++; $display("FAIL rst_data got=%h want=0", rd_data); end
    set_word(splat(12'h800), 1'b1);
    tick(); tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_no_arm busy got=%b want=0", busy); end
  endtask

  task automatic test_immediate();
    logic [95:0] w;
    trig_mode = 1'b0;
    sent.delete();
    set_word(splat(12'h7FF), 1'b1);
    pulse_arm();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL imm_armed busy got=%b want=1", busy); end
    for (int k = 0; k < 256; k++) begin
      w = splat(12'h800 + 12'(k));
      set_word(w, 1'b1);
      sent.push_back(w);
      tick();
      if (k == 254) begin
        total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL imm_capt254 busy,done got=%b want=10", {busy, done}); end
      end
    end
    set_word('0, 1'b0);
    total++; if ({busy, done} !== 2'b01) begin bad++; $display("FAIL imm_read busy,done got=%b want=01", {busy, done}); end
    read_words(256, 100);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL imm_timeout got=%0d words want=256", got_q.size()); end
    total++; if (first_cyc < 0 || first_cyc > 2) begin bad++; $display("FAIL imm_first_valid got=%0d want<=2", first_cyc); end
    total++; if (last_cyc - first_cyc !== 255) begin bad++; $display("FAIL imm_no_bubble span got=%0d want=255", last_cyc - first_cyc); end
    for (int k = 0; k < 256; k++) begin
      w = (k < got_q.size()) ? got_q[k] : 'x;
      total++; if (w !== exp_of(sent[k])) begin bad++; $display("FAIL imm_word%0d got=%h want=%h", k, w, exp_of(sent[k])); end
      total++; if (k < got_last.size() && got_last[k] !== (k == 255)) begin bad++; $display("FAIL imm_last%0d got=%b want=%b", k, got_last[k], k == 255); end
    end
    total++; if ({busy, done, rd_valid} !== 3'b000) begin bad++; $display("FAIL imm_idle got=%b want=000", {busy, done, rd_valid}); end
  endtask

  task automatic test_level();
    logic [11:0] pre [5] = '{12'h800, 12'h864, 12'h8C8, 12'h60D, 12'h990};
    logic [95:0] w;
    logic [95:0] tw;
    tw = {12'h9F4, 12'hFFF, 12'h800, 12'hFFF, 12'h800, 12'hFFF, 12'h800, 12'hFFF};
    trig_mode  = 1'b1;
    trig_level = 11'd500;
    sent.delete();
    set_word('0, 1'b0);
    pulse_arm();
    set_word(mkw(12'hFFF, 12'h000), 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      set_word(mkw(12'hFFF, pre[i]), 1'b1);
      tick();
    end
    total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL lvl_armed busy,done got=%b want=10", {busy, done}); end
    set_word(tw, 1'b1);
    sent.push_back(tw);
    tick();
    for (int k = 1; k < 256; k++) begin
      w = mkw(12'hFFF, 12'h800 + 12'd500 + 12'(k));
      set_word(w, 1'b1);
      sent.push_back(w);
      tick();
      if (k == 254) begin
        total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL lvl_capt254 busy,done got=%b want=10", {busy, done}); end
      end
    end
    set_word('0, 1'b0);
    total++; if ({busy, done} !== 2'b01) begin bad++; $display("FAIL lvl_read busy,done got=%b want=01", {busy, done}); end
    read_words(256, 100);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL lvl_timeout got=%0d words want=256", got_q.size()); end
    for (int k = 0; k < 256; k++) begin
      w = (k < got_q.size()) ? got_q[k] : 'x;
      total++; if (w !== exp_of(sent[k])) begin bad++; $display("FAIL lvl_word%0d got=%h want=%h", k, w, exp_of(sent[k])); end
    end
    trig_mode = 1'b0;
  endtask

  task automatic test_dv_gaps();
    logic [95:0] w;
    trig_mode = 1'b0;
    sent.delete();
    set_word('0, 1'b0);
    pulse_arm();
    for (int n = 0; n < 511; n++) begin
      if (n % 2 == 0) begin
        w = splat(12'h100 + 12'(n / 2));
        set_word(w, 1'b1);
        sent.push_back(w);
      end else begin
        set_word(splat(12'hABC), 1'b0);
      end
      tick();
      if (n == 509) begin
        total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL dv_capt509 busy,done got=%b want=10", {busy, done}); end
      end
    end
    set_word('0, 1'b0);
    total++; if ({busy, done} !== 2'b01) begin bad++; $display("FAIL dv_read busy,done got=%b want=01", {busy, done}); end
  endtask

  task automatic test_backpressure();
    logic [95:0] w;
    read_words(256, 30);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL bp_timeout got=%0d words want=256", got_q.size()); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL bp_stable changes got=%0d want=0", unstable); end
    for (int k = 0; k < 256; k++) begin
      w = (k < got_q.size()) ? got_q[k] : 'x;
      total++; if (w !== exp_of(sent[k])) begin bad++; $display("FAIL bp_word%0d got=%h want=%h", k, w, exp_of(sent[k])); end
      total++; if (k < got_last.size() && got_last[k] !== (k == 255)) begin bad++; $display("FAIL bp_last%0d got=%b want=%b", k, got_last[k], k == 255); end
    end
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL bp_idle busy,done got=%b want=00", {busy, done}); end
  endtask

  task automatic test_arm_abort();
    logic [95:0] w;
    trig_mode = 1'b0;
    sent.delete();
    set_word(splat(12'hF00), 1'b1);
    pulse_arm();
    for (int k = 0; k < 256; k++) begin
      w = splat(12'h200 + 12'(k));
      set_word(w, 1'b1);
      sent.push_back(w);
      arm = (k == 50);
      tick();
      arm = 1'b0;
      if (k == 254) begin
        total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL abort_capt254 busy,done got=%b want=10", {busy, done}); end
      end
    end
    total++; if ({busy, done} !== 2'b01) begin bad++; $display("FAIL abort_read busy,done got=%b want=01", {busy, done}); end
    read_words(100, 100);
    for (int k = 0; k < 100; k++) begin
      w = (k < got_q.size()) ? got_q[k] : 'x;
      total++; if (w !== exp_of(sent[k])) begin bad++; $display("FAIL abort_word%0d got=%h want=%h", k, w, exp_of(sent[k])); end
    end
    total++; if (rd_valid !== 1'b1 || rd_data !== exp_of(sent[100])) begin bad++; $display("FAIL abort_word100 got=%b/%h want=1/%h", rd_valid, rd_data, exp_of(sent[100])); end
    set_word(splat(12'hEEE), 1'b1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL abort_valid_drop got=%b want=0", rd_valid); end
    total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL abort_state busy,done got=%b want=10", {busy, done}); end
    sent.delete();
    for (int k = 0; k < 256; k++) begin
      w = splat(12'h300 + 12'(k));
      set_word(w, 1'b1);
      sent.push_back(w);
      tick();
    end
    set_word('0, 1'b0);
    total++; if ({busy, done} !== 2'b01) begin bad++; $display("FAIL rearm_read busy,done got=%b want=01", {busy, done}); end
  endtask

  task automatic test_back_to_back();
    logic [95:0] w;
    read_words(255, 100);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL b2b_timeout got=%0d words want=255", got_q.size()); end
    for (int k = 0; k < 255; k++) begin
      w = (k < got_q.size()) ? got_q[k] : 'x;
      total++; if (w !== exp_of(sent[k])) begin bad++; $display("FAIL b2b_word%0d got=%h want=%h", k, w, exp_of(sent[k])); end
    end
    total++; if ({rd_valid, rd_last} !== 2'b11 || rd_data !== exp_of(sent[255])) begin bad++; $display("FAIL b2b_final got=%b/%h want=11/%h", {rd_valid, rd_last}, rd_data, exp_of(sent[255])); end
    set_word(splat(12'h555), 1'b0);
    rd_ready = 1'b1;
    arm      = 1'b1;
    tick();
    arm      = 1'b0;
    rd_ready = 1'b0;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid got=%b want=0", rd_valid); end
    total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL b2b_arm_wins busy,done got=%b want=10", {busy, done}); end
    tick(); tick(); tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_still_armed busy got=%b want=1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_rst busy got=%b want=0", busy); end
  endtask

  task automatic test_rst_mid();
    logic [95:0] w;
    trig_mode = 1'b0;
    set_word('0, 1'b0);
    pulse_arm();
    for (int k = 0; k <= 40; k++) begin
      set_word(splat(12'h400 + 12'(k)), 1'b1);
      rst = (k == 40);
      tick();
    end
    rst = 1'b0;
    total++; if ({busy, done, rd_valid, rd_last} !== 4'b0000) begin bad++; $display("FAIL rstmid_flags got=%b want=0000", {busy, done, rd_valid, rd_last}); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL rstmid_data got=%h want=0", rd_data); end
    tick(); tick(); tick();
    total++; if ({busy, rd_valid} !== 2'b00) begin bad++; $display("FAIL rstmid_idle got=%b want=00", {busy, rd_valid}); end
    sent.delete();
    set_word('0, 1'b0);
    pulse_arm();
    for (int k = 0; k < 256; k++) begin
      w = splat(12'h600 + 12'(k));
      set_word(w, 1'b1);
      sent.push_back(w);
      tick();
    end
    set_word('0, 1'b0);
    total++; if ({busy, done} !== 2'b01) begin bad++; $display("FAIL rstmid_read busy,done got=%b want=01", {busy, done}); end
    read_words(256, 100);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL rstmid_timeout got=%0d words want=256", got_q.size()); end
    for (int k = 0; k < 256; k++) begin
      w = (k < got_q.size()) ? got_q[k] : 'x;
      total++; if (w !== exp_of(sent[k])) begin bad++; $display("FAIL rstmid_word%0d got=%h want=%h", k, w, exp_of(sent[k])); end
      total++; if (k < got_last.size() && got_last[k] !== (k == 255)) begin bad++; $display("FAIL rstmid_last%0d got=%b want=%b", k, got_last[k], k == 255); end
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_level();
    test_dv_gaps();
    test_backpressure();
    test_arm_abort();
    test_back_to_back();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
